// File: rtl/mem_fill_wb_unit.sv
// Line-fill sequencer with a small write-back buffer between L2 and main memory.
// Fills that match a queued victim are forwarded from the buffer without a memory read.
module mem_fill_wb_unit #(
    parameter int unsigned MEM_LATENCY = 10,
    parameter int unsigned WB_DEPTH    = 2,
    parameter int unsigned LINE_ADDR_W = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fill_req,
    input  logic [LINE_ADDR_W-1:0] fill_addr,
    output logic                   fill_done,
    output logic [31:0]            fill_data,
    output logic                   busy,
    input  logic                   wb_valid,
    input  logic [LINE_ADDR_W-1:0] wb_addr,
    input  logic [31:0]            wb_data,
    output logic                   wb_ready,
    output logic [31:0]            mem_rd_address,
    input  logic [31:0]            mem_rd_data,
    output logic                   mem_wr_en,
    output logic [31:0]            mem_wr_address,
    output logic [31:0]            mem_wr_data
);

    localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] FILL   = 2'd2;
    localparam logic [1:0] WRITE  = 2'd3;

    localparam logic [3:0]       LAT_M1   = 4'(MEM_LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_DEPTH);

    logic [1:0]             state;
    logic [3:0]             cnt;
    logic [LINE_ADDR_W-1:0] req_addr;
    logic [LINE_ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [31:0]            wb_data_q [WB_DEPTH];
    logic [WB_DEPTH-1:0]    wb_vld_q;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;

    logic        full;
    logic        push;
    logic        pop;
    logic        hit;
    logic [31:0] hit_data;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full           = (count == CNT_FULL);
    assign wb_ready       = !reset && !full;
    assign push           = wb_valid && wb_ready;
    assign pop            = (state == WRITE) && (cnt == '0);
    assign mem_wr_en      = pop;
    assign mem_wr_address = 32'({wb_addr_q[head], 2'b00});
    assign mem_wr_data    = wb_data_q[head];
    assign busy           = (state != IDLE);

    // Walk oldest to youngest so the last match (youngest copy) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            if (wb_vld_q[head + PTR_W'(i)] && (wb_addr_q[head + PTR_W'(i)] == req_addr)) begin
                hit      = 1'b1;
                hit_data = wb_data_q[head + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            req_addr       <= '0;
            fill_done      <= 1'b0;
            fill_data      <= '0;
            mem_rd_address <= '0;
            wb_vld_q       <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            for (int i = 0; i < int'(WB_DEPTH); i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
        end else begin
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (full) begin
                        state <= WRITE;
                        cnt   <= LAT_M1;
                    end else if (fill_req && !fill_done) begin
                        state          <= LOOKUP;
                        req_addr       <= fill_addr;
                        mem_rd_address <= 32'({fill_addr, 2'b00});
                    end else if (count != '0) begin
                        state <= WRITE;
                        cnt   <= LAT_M1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        fill_data <= hit_data;
                        fill_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= FILL;
                        cnt   <= LAT_M1;
                    end
                end
                FILL: begin
                    if (cnt == '0) begin
                        fill_data <= mem_rd_data;
                        fill_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wb_addr_q[tail] <= wb_addr;
                wb_data_q[tail] <= wb_data;
                wb_vld_q[tail]  <= 1'b1;
                tail            <= ptr_next(tail);
            end
            if (pop) begin
                wb_vld_q[head] <= 1'b0;
                head           <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
